// File: rtl/minisys_bus_pkg.sv
// Shared MiniSys bus types: arbiter state encoding, master indices, default data width.
package minisys_bus_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [1:0] M_IF  = 2'd0;
  localparam logic [1:0] M_MEM = 2'd1;
  localparam logic [1:0] M_DMA = 2'd2;
  localparam logic [1:0] M_DBG = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester after last_ptr, wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last_ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from farthest to nearest so the nearest hit wins; the last owner sits at offset 4.
  always_comb begin
    found = 1'b0;
    idx   = last_ptr;
    cand  = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_ptr + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-master round-robin bus arbiter with hold limit and a registered 4:1 data path.
module bus_arbiter4
  import minisys_bus_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] out
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]        last_ptr_q, last_ptr_d;

  logic              pick_found;
  logic [1:0]        pick_idx;
  logic              owner_req;
  logic              other_pend;
  logic              do_grant;
  logic [DATA_W-1:0] mux_word;

  rr_pick4 u_pick (
    .req      (req),
    .last_ptr (last_ptr_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // gnt_q is the owner's one-hot mask while in GRANT and zero in IDLE.
  assign owner_req  = |(req & gnt_q);
  assign other_pend = |(req & ~gnt_q);

  always_comb begin
    case (sel_q)
      2'd0:    mux_word = in0;
      2'd1:    mux_word = in1;
      2'd2:    mux_word = in2;
      default: mux_word = in3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    last_ptr_d = last_ptr_q;
    do_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) do_grant = 1'b1;
      end
      GRANT: begin
        // Release takes precedence over hold expiry.
        if (!owner_req) begin
          if (pick_found) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (other_pend) begin
          if (hold_cnt_q == HOLD_LAST) do_grant = 1'b1;
          else                         hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d    = GRANT;
      gnt_d      = 4'b0001 << pick_idx;
      sel_d      = pick_idx;
      busy_d     = 1'b1;
      hold_cnt_d = '0;
      last_ptr_d = pick_idx;
    end

    valid_d = busy_q;
    out_d   = busy_q ? mux_word : out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      out_q      <= '0;
      hold_cnt_q <= '0;
      last_ptr_q <= 2'd3;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
      hold_cnt_q <= hold_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign out   = out_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboarded bench for bus_arbiter4: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_bus_arbiter4;

  localparam int MAX_HOLD = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = 4'b0000;
  logic [31:0] din [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        busy;
  logic        valid;
  logic [31:0] out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter4 #(.DATA_W(32), .MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .in0   (din[0]),
    .in1   (din[1]),
    .in2   (din[2]),
    .in3   (din[3]),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .valid (valid),
    .out   (out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_owner = -1;
  int          m_cnt   = 0;
  int          m_last  = 3;
  logic [3:0]  e_gnt   = 4'b0000;
  logic [1:0]  e_sel   = 2'd0;
  logic        e_busy  = 1'b0;
  logic        e_valid = 1'b0;
  logic [31:0] data_q [$];

  function automatic int rr_winner(input logic [3:0] r, input int last);
    int m;
    for (int k = 1; k <= 4; k++) begin
      m = (last + k) % 4;
      if (r[m]) return m;
    end
    return -1;
  endfunction

  function automatic bit others_pending(input logic [3:0] r, input int owner);
    for (int m = 0; m < 4; m++)
      if (m != owner && r[m]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 3;
      e_sel   = 2'd0;
      e_valid = 1'b0;
      data_q.delete();
    end else begin
      e_valid = (m_owner >= 0);
      if (m_owner >= 0) data_q.push_back(din[m_owner]);
      w = rr_winner(req, m_last);
      if (m_owner < 0 || !req[m_owner]) begin
        m_owner = w;
        if (w >= 0) begin m_cnt = 0; m_last = w; e_sel = 2'(w); end
      end else if (others_pending(req, m_owner)) begin
        if (m_cnt == MAX_HOLD - 1) begin
          m_owner = w; m_cnt = 0; m_last = w; e_sel = 2'(w);
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    e_gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e_busy = (m_owner >= 0);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    check("mon_gnt",   32'(gnt),   32'(e_gnt));
    check("mon_sel",   32'(sel),   32'(e_sel));
    check("mon_busy",  32'(busy),  32'(e_busy));
    check("mon_valid", 32'(valid), 32'(e_valid));
    if (valid) begin
      if (data_q.size() == 0) check("mon_out_unexpected", 32'(valid), 32'd0);
      else check("mon_out", out, data_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) din[i] = $urandom;
    din[0] = 32'hDEADBEEF;
    repeat (2) tick;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_out", out, 32'd0);
    rst_n = 1'b1;

    // single request
    req = 4'b0001;
    tick;
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_sel", 32'(sel), 32'd0);
    tick;
    check("single_valid", 32'(valid), 32'd1);
    check("single_out", out, 32'hDEADBEEF);
    req = 4'b0000;
    repeat (2) tick;

    // lone master holds indefinitely
    req = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      tick;
      check("lone_gnt", 32'(gnt), 32'h2);
    end
    req = 4'b0000;
    tick;
    check("lone_rel_gnt", 32'(gnt), 32'h0);
    check("lone_rel_busy", 32'(busy), 32'd0);
    check("lone_rel_valid", 32'(valid), 32'd1);
    tick;
    check("lone_rel_valid2", 32'(valid), 32'd0);

    // early release hands over without a dead cycle
    req = 4'b0100;
    tick;
    check("early_own2", 32'(gnt), 32'h4);
    req = 4'b1001;
    tick;
    check("early_to3", 32'(gnt), 32'h8);
    req = 4'b0001;
    tick;
    check("early_to0", 32'(gnt), 32'h1);
    req = 4'b0000;
    repeat (2) tick;

    // owner drops exactly at hold expiry
    req = 4'b0110;
    tick;
    check("exp_own1", 32'(gnt), 32'h2);
    repeat (7) tick;
    check("exp_still1", 32'(gnt), 32'h2);
    req = 4'b0100;
    tick;
    check("exp_rel_to2", 32'(gnt), 32'h4);
    req = 4'b0110;
    for (int i = 0; i < 7; i++) begin
      tick;
      check("exp_hold2", 32'(gnt), 32'h4);
    end
    tick;
    check("exp_preempt_to1", 32'(gnt), 32'h2);
    req = 4'b0000;
    repeat (2) tick;

    // async reset mid-grant
    din[2] = 32'h1234_5678;
    req = 4'b0100;
    tick;
    check("ar_own2", 32'(gnt), 32'h4);
    tick;
    #1 rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 32'h0);
    check("ar_sel", 32'(sel), 32'd0);
    check("ar_valid", 32'(valid), 32'd0);
    check("ar_out", out, 32'd0);
    tick;
    rst_n = 1'b1;
    req = 4'b1100;
    tick;
    check("ar_first_gnt", 32'(gnt), 32'h4);
    check("ar_first_sel", 32'(sel), 32'd2);

    // all masters requesting from reset
    req = 4'b0000;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      tick;
      check("all_owner", 32'(gnt), 32'(4'b0001 << ((k / MAX_HOLD) % 4)));
    end

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      tick;
    end

    req = 4'b0000;
    repeat (4) tick;
    check("drain_empty", 32'(data_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
